// File: rtl/uart_rx_oversampler.sv
// UART receiver with 16x oversampling: mid-bit sampling, optional parity, and a
// valid/ready holding register with parity, framing and overrun error pulses.
module uart_rx_oversampler #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_16x,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned BYTE_W = 8;

   localparam logic [CNT_W-1:0] MID_TICK = CNT_W'(7);
   localparam logic [CNT_W-1:0] END_TICK = CNT_W'(15);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
   localparam logic             PAR_ODD  = 1'(PARITY_ODD);
   localparam logic             HAS_PAR  = (PARITY_EN != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
   logic [BYTE_W-1:0]   shift, shift_n;
   logic                armed, armed_n;
   logic                parity_bad, parity_bad_n;
   logic                frame_done_c;
   logic                stop_ok_c;
   logic                rx_meta, rx_s;

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         armed      <= 1'b0;
         parity_bad <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_cnt    <= bit_cnt_n;
         shift      <= shift_n;
         armed      <= armed_n;
         parity_bad <= parity_bad_n;
      end
   end

   // Next-state logic; everything holds between ticks.
   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      bit_cnt_n    = bit_cnt;
      shift_n      = shift;
      armed_n      = armed;
      parity_bad_n = parity_bad;
      frame_done_c = 1'b0;
      stop_ok_c    = 1'b0;
      if (tick_16x) begin
         case (state)
            IDLE: begin
               if (!armed) begin
                  if (rx_s) armed_n = 1'b1;
               end else if (!rx_s) begin
                  state_n      = START;
                  cnt_n        = '0;
                  bit_cnt_n    = '0;
                  shift_n      = '0;
                  parity_bad_n = 1'b0;
               end
            end
            START: begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt == MID_TICK) begin
                  cnt_n   = '0;
                  state_n = rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt == END_TICK) begin
                  shift_n[bit_cnt] = rx_s;
                  if (bit_cnt == LAST_BIT) begin
                     state_n = HAS_PAR ? PARITY : STOP;
                  end else begin
                     bit_cnt_n = bit_cnt + BIT_W'(1);
                  end
               end
            end
            PARITY: begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt == END_TICK) begin
                  parity_bad_n = (rx_s != ((^shift) ^ PAR_ODD));
                  state_n      = STOP;
               end
            end
            STOP: begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt == END_TICK) begin
                  frame_done_c = 1'b1;
                  stop_ok_c    = rx_s;
                  armed_n      = rx_s;
                  state_n      = IDLE;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // Output holding register and one-clk error pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         parity_err  <= 1'b0;
         framing_err <= 1'b0;
         overrun_err <= 1'b0;
         busy        <= (state_n != IDLE);
         if (frame_done_c && stop_ok_c) begin
            if (rx_valid && !rx_ready) begin
               overrun_err <= 1'b1;
            end else begin
               rx_data    <= shift;
               rx_valid   <= 1'b1;
               parity_err <= parity_bad;
            end
         end else begin
            if (frame_done_c) framing_err <= 1'b1;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scoreboard bench for uart_rx_oversampler: an 8N1 instance and an 8E1 instance
// share clock, reset and tick; expected output events are queued by the stimulus.
module tb_uart_rx_oversampler;

   localparam int unsigned BIT_CLKS = 64;
   localparam logic [2:0]  K_DATA   = 3'd1;
   localparam logic [2:0]  K_PERR   = 3'd2;
   localparam logic [2:0]  K_FERR   = 3'd3;
   localparam logic [2:0]  K_OERR   = 3'd4;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick_16x = 1'b0;
   logic       rx, rx_p;
   logic       rx_ready, rx_ready_p;
   logic [7:0] rx_data, rx_data_p;
   logic       rx_valid, rx_valid_p;
   logic       parity_err, parity_err_p;
   logic       framing_err, framing_err_p;
   logic       overrun_err, overrun_err_p;
   logic       busy, busy_p;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          tick_phase = 0;
   logic [11:0] exp_q[$];
   logic        prev_tick = 1'b0;
   logic        prev_v0 = 1'b0;
   logic        prev_v1 = 1'b0;

   uart_rx_oversampler dut (
      .clk(clk), .reset(reset), .tick_16x(tick_16x), .rx(rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .parity_err(parity_err), .framing_err(framing_err),
      .overrun_err(overrun_err), .busy(busy)
   );

   uart_rx_oversampler #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .clk(clk), .reset(reset), .tick_16x(tick_16x), .rx(rx_p),
      .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
      .parity_err(parity_err_p), .framing_err(framing_err_p),
      .overrun_err(overrun_err_p), .busy(busy_p)
   );

   always #5 clk = ~clk;

   // 16x tick: one clk in every four.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tick_phase = (tick_phase + 1) % 4;
         tick_16x   = (tick_phase == 3);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic observe(input logic [11:0] ev);
      logic [11:0] exp_ev;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: got 0x%03h required none", ev);
      end else begin
         exp_ev = exp_q.pop_front();
         check("event", 32'(ev), 32'(exp_ev));
      end
   endtask

   task automatic mon(input logic id, input logic v, input logic rdy, input logic [7:0] d,
                      input logic pe, input logic fe, input logic oe);
      if (pe === 1'b1) observe({id, K_PERR, 8'h00});
      if (fe === 1'b1) observe({id, K_FERR, 8'h00});
      if (oe === 1'b1) observe({id, K_OERR, 8'h00});
      if (v === 1'b1 && rdy === 1'b1) observe({id, K_DATA, d});
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard on every output event.
   always @(negedge clk) begin
      mon(1'b0, rx_valid, rx_ready, rx_data, parity_err, framing_err, overrun_err);
      mon(1'b1, rx_valid_p, rx_ready_p, rx_data_p, parity_err_p, framing_err_p, overrun_err_p);
      if (rx_valid === 1'b1 && prev_v0 !== 1'b1) begin
         check("valid_after_tick", 32'(prev_tick), 32'd1);
         check("busy_at_valid", 32'(busy), 32'd0);
      end
      if (rx_valid_p === 1'b1 && prev_v1 !== 1'b1) begin
         check("valid_after_tick_p", 32'(prev_tick), 32'd1);
         check("busy_at_valid_p", 32'(busy_p), 32'd0);
      end
      prev_tick <= tick_16x;
      prev_v0   <= rx_valid;
      prev_v1   <= rx_valid_p;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic which, input logic v);
      if (which) rx_p = v;
      else       rx   = v;
      wait_clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic which, input logic [7:0] d, input logic par_en,
                             input logic par_bit, input logic stop_bit);
      drive(which, 1'b0);
      for (int i = 0; i < 8; i++) drive(which, d[i]);
      if (par_en) drive(which, par_bit);
      drive(which, stop_bit);
   endtask

   initial begin
      reset      = 1'b1;
      rx         = 1'b1;
      rx_p       = 1'b1;
      rx_ready   = 1'b1;
      rx_ready_p = 1'b1;
      wait_clks(3);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_errs", 32'({parity_err, framing_err, overrun_err}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_p", 32'({rx_data_p, rx_valid_p, busy_p}), 32'd0);
      reset = 1'b0;
      wait_clks(128);

      // 8N1 byte 0xA5
      exp_q.push_back({1'b0, K_DATA, 8'hA5});
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      wait_clks(64);
      check("a5_busy_idle", 32'(busy), 32'd0);

      // 5-tick low glitch aborts at the mid-bit check
      rx = 1'b0;
      wait_clks(16);
      check("glitch_busy", 32'(busy), 32'd1);
      wait_clks(4);
      rx = 1'b1;
      wait_clks(60);
      check("glitch_busy_clear", 32'(busy), 32'd0);
      check("glitch_no_valid", 32'(rx_valid), 32'd0);
      wait_clks(64);

      // even parity, 0x03 with wrong parity bit 1
      exp_q.push_back({1'b1, K_PERR, 8'h00});
      exp_q.push_back({1'b1, K_DATA, 8'h03});
      send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
      wait_clks(64);

      // framing error, line held low afterwards must not start a frame
      exp_q.push_back({1'b0, K_FERR, 8'h00});
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      wait_clks(128);
      check("ferr_busy_disarmed", 32'(busy), 32'd0);
      check("ferr_no_valid", 32'(rx_valid), 32'd0);
      check("ferr_data_kept", 32'(rx_data), 32'hA5);
      rx = 1'b1;
      wait_clks(64);
      exp_q.push_back({1'b0, K_DATA, 8'h55});
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      wait_clks(64);

      // overrun with consumer stalled
      rx_ready = 1'b0;
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      wait_clks(64);
      check("ovr_valid1", 32'(rx_valid), 32'd1);
      check("ovr_data1", 32'(rx_data), 32'h11);
      exp_q.push_back({1'b0, K_OERR, 8'h00});
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      wait_clks(64);
      check("ovr_data_kept", 32'(rx_data), 32'h11);
      check("ovr_valid_kept", 32'(rx_valid), 32'd1);
      exp_q.push_back({1'b0, K_DATA, 8'h11});
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
      check("ovr_valid_drop", 32'(rx_valid), 32'd0);
      rx_ready = 1'b1;
      wait_clks(64);

      // reset during data bit 3 of 0x3C, then a clean 0x3C frame
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      rx = 1'b1;
      wait_clks(32);
      check("mid_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      wait_clks(1);
      reset = 1'b0;
      check("mid_rst_data", 32'(rx_data), 32'h00);
      check("mid_rst_valid", 32'(rx_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_errs", 32'({parity_err, framing_err, overrun_err}), 32'd0);
      wait_clks(128);
      check("mid_idle_busy", 32'(busy), 32'd0);
      exp_q.push_back({1'b0, K_DATA, 8'h3C});
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_clks(128);
      check("post_rst_data", 32'(rx_data), 32'h3C);

      check("pending_events", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
